dmem_responder: RTL and testbench

//  Data-memory responder on the far side of the MEM-stage load/store interface.

---
 rtl/dmem_responder.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder behind the MEM-stage load/store port. It accepts one
//   word request at a time and completes it after WAIT_CYCLES wait states. It
//   holds mem_stall high so the pipeline freezes until the response cycle.
//   Loads return data with a one-cycle rdata_valid strobe.
//
//   Optional feature macro: DMEM_BYTE_STROBE_EN
//     defined   : adds a wstrb[3:0] input. Stores update only the strobed byte
//                 lanes.
//     undefined : there is no wstrb port. Every store writes the full word.
//
// Handshake (request/stall):
//   The pipeline presents mem_read/mem_write with addr/wdata. The responder
//   accepts the request in the first IDLE cycle in which it sees the request.
//   In that same cycle mem_stall rises combinationally. mem_stall stays high
//   through the last wait cycle. It drops in the RESP cycle, so the pipeline
//   advances on the RESP clock edge. The next IDLE cycle therefore sees the
//   following instruction's request and never re-accepts the old one. Request
//   inputs are sampled only at accept time, so later changes are ignored.
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
`ifdef DMEM_BYTE_STROBE_EN
   input  logic [3:0]  wstrb,
`endif
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        mem_stall,
   output logic        misalign_err
);

   // ---------------------------------------------------------------------------
   // Local definitions
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
   localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

   // ---------------------------------------------------------------------------
   // State, latched request and output registers
   // ---------------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;

   logic [ADDR_W-1:0]   idx_q, idx_d;        // latched word index
   logic                mis_q, mis_d;        // latched misalignment flag
   logic                op_wr_q, op_wr_d;    // latched store (wins over read)
   logic                op_rd_q, op_rd_d;    // latched pure load
   logic [31:0]         wdata_q, wdata_d;
`ifdef DMEM_BYTE_STROBE_EN
   logic [3:0]          wstrb_q, wstrb_d;
`endif

   logic [31:0]         rdata_q, rdata_d;
   logic                rdata_valid_q, rdata_valid_d;
   logic                misalign_q, misalign_d;

   // Storage array: deliberately not reset.
   logic [31:0]         mem_q [DEPTH_WORDS];

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   logic                req;          // any request present on the inputs
   logic                take_req;     // request accepted this cycle
   logic                enter_resp;   // next cycle is the response cycle
   logic                do_store;     // array write on this clock edge
   logic [ADDR_W-1:0]   in_idx;
   logic                in_mis;
   logic [ADDR_W-1:0]   eff_idx;      // request view used when entering RESP
   logic                eff_mis;
   logic                eff_load;
   logic                unused_addr_hi;

   assign req    = mem_read | mem_write;
   assign in_idx = addr[ADDR_W+1:2];
   assign in_mis = (addr[1:0] != 2'b00);

   // Upper address bits only select which alias of the array is addressed.
   assign unused_addr_hi = ^addr[31:ADDR_W+2];

   // With zero wait states the response cycle follows the accept cycle
   // directly. In that case the registered outputs must use the live inputs.
   // Otherwise they use the latched copy.
   assign eff_idx  = (state_q == S_IDLE) ? in_idx : idx_q;
   assign eff_mis  = (state_q == S_IDLE) ? in_mis : mis_q;
   assign eff_load = (state_q == S_IDLE) ? (mem_read & ~mem_write) : op_rd_q;

   // ---------------------------------------------------------------------------
   // FSM process 1: state and wait counter register
   // ---------------------------------------------------------------------------
   // Hold FSM state and wait counter; reset aborts any pending request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM process 2: next-state and counter logic
   // ---------------------------------------------------------------------------
   // Sequence IDLE -> WAIT -> RESP -> IDLE, skipping WAIT for zero wait states.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               cnt_d   = WAIT_INIT;
               state_d = ZERO_WAIT ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM process 3: output decode
   // ---------------------------------------------------------------------------
   // Stall from accept through the last wait cycle; flag the store and response edges.
   always_comb begin
      mem_stall  = 1'b0;
      take_req   = 1'b0;
      do_store   = 1'b0;
      enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
      unique case (state_q)
         S_IDLE: begin
            take_req  = req;
            mem_stall = req;
         end
         S_WAIT: begin
            mem_stall = 1'b1;
         end
         S_RESP: begin
            do_store = op_wr_q & ~mis_q;
         end
         default: begin
            mem_stall = 1'b0;
         end
      endcase
      // Never freeze the pipeline while reset is held.
      if (rst) begin
         mem_stall = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Request latch
   // ---------------------------------------------------------------------------
   // Capture the request at accept time so inputs may change afterwards.
   always_comb begin
      idx_d   = idx_q;
      mis_d   = mis_q;
      op_wr_d = op_wr_q;
      op_rd_d = op_rd_q;
      wdata_d = wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
      wstrb_d = wstrb_q;
`endif
      if (take_req) begin
         idx_d   = in_idx;
         mis_d   = in_mis;
         op_wr_d = mem_write;
         op_rd_d = mem_read & ~mem_write;
         wdata_d = wdata;
`ifdef DMEM_BYTE_STROBE_EN
         wstrb_d = wstrb;
`endif
      end
   end

   // Register the latched request fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         mis_q   <= 1'b0;
         op_wr_q <= 1'b0;
         op_rd_q <= 1'b0;
         wdata_q <= 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
         wstrb_q <= 4'd0;
`endif
      end else begin
         idx_q   <= idx_d;
         mis_q   <= mis_d;
         op_wr_q <= op_wr_d;
         op_rd_q <= op_rd_d;
         wdata_q <= wdata_d;
`ifdef DMEM_BYTE_STROBE_EN
         wstrb_q <= wstrb_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Storage array write
   // ---------------------------------------------------------------------------
`ifdef DMEM_BYTE_STROBE_EN
   // Write only the strobed byte lanes of an aligned store at the end of RESP.
   always_ff @(posedge clk) begin
      if (do_store) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
               mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end
`else
   // Write the full word of an aligned store at the end of RESP.
   always_ff @(posedge clk) begin
      if (do_store) begin
         mem_q[idx_q] <= wdata_q;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Registered response outputs
   // ---------------------------------------------------------------------------
   // Compute response values that become visible during the RESP cycle.
   always_comb begin
      rdata_d       = rdata_q;
      rdata_valid_d = enter_resp & eff_load;
      misalign_d    = enter_resp & eff_mis;
      if (enter_resp && eff_load) begin
         rdata_d = eff_mis ? 32'd0 : mem_q[eff_idx];
      end
   end

   // Register the response strobes and load data; rdata holds between loads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q       <= 32'd0;
         rdata_valid_q <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         misalign_q    <= misalign_d;
      end
   end

   assign rdata        = rdata_q;
   assign rdata_valid  = rdata_valid_q;
   assign misalign_err = misalign_q;

   // ---------------------------------------------------------------------------
   // Protocol properties
   // ---------------------------------------------------------------------------
   // Response strobes occur only in the RESP cycle, never while stalling.
   a_valid_in_resp : assert property (@(posedge clk) disable iff (rst)
      rdata_valid |-> (state_q == S_RESP && !mem_stall));

   a_mis_in_resp : assert property (@(posedge clk) disable iff (rst)
      misalign_err |-> (state_q == S_RESP));

   // The wait counter never runs out while the FSM is still waiting.
   a_wait_cnt : assert property (@(posedge clk) disable iff (rst)
      (state_q == S_WAIT) |-> (cnt_q != 4'd0));

   // RESP always lasts exactly one cycle.
   a_resp_once : assert property (@(posedge clk) disable iff (rst)
      (state_q == S_RESP) |=> (state_q == S_IDLE));

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed testbench for dmem_responder with WAIT_CYCLES = 2. Each scenario
//   task drives requests through drive_req and compares the per-cycle traces
//   against hand-derived values. With two wait states, a request in cycle T
//   gives stall in cycles T..T+2 and a response in cycle T+3.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int W = 2;
   // Bits 0..W set: stall in the accept cycle and in each wait cycle.
   localparam logic [7:0] STALL_EXP = 8'h07;
   // Only bit W+1 set: strobe in the response cycle alone.
   localparam logic [7:0] RESP_BIT  = 8'h08;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        mem_stall;
   logic        misalign_err;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_WORDS (256),
      .ADDR_W      (8),
      .WAIT_CYCLES (W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .addr         (addr),
      .wdata        (wdata),
`ifdef DMEM_BYTE_STROBE_EN
      .wstrb        (wstrb),
`endif
      .rdata        (rdata),
      .rdata_valid  (rdata_valid),
      .mem_stall    (mem_stall),
      .misalign_err (misalign_err)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Driver: call just after a posedge. Presents a request and samples
   // stall/valid/misalign at each negedge from cycle T to cycle T+W+1. It then
   // drops the request just after the RESP edge.
   // ---------------------------------------------------------------------------
   task automatic drive_req(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] strb,
                            input logic scramble,
                            output logic [7:0] stall_tr, output logic [7:0] valid_tr,
                            output logic [7:0] mis_tr, output logic [31:0] rdata_resp);
      stall_tr   = 8'd0;
      valid_tr   = 8'd0;
      mis_tr     = 8'd0;
      rdata_resp = 32'd0;
      mem_read   = rd;
      mem_write  = wr;
      addr       = a;
      wdata      = wd;
      wstrb      = strb;
      for (int i = 0; i <= W + 1; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
            if (scramble && i <= W) begin
               addr  = $urandom;
               wdata = $urandom;
               wstrb = 4'($urandom_range(0, 15));
            end
         end
         @(negedge clk);
         stall_tr[i] = mem_stall;
         valid_tr[i] = rdata_valid;
         mis_tr[i]   = misalign_err;
         if (i == W + 1) rdata_resp = rdata;
      end
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr      = 32'd0;
      wdata     = 32'd0;
      wstrb     = 4'hF;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0; wstrb = 4'hF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'd0); end
      n_cmp++; if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rdata_valid); end
      n_cmp++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b expected 0", misalign_err); end
      mem_read = 1'b1;
      #1;
      n_cmp++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_gated: got %b expected 0", mem_stall); end
      mem_read = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall: got %b expected 0", mem_stall); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_store_load();
      logic [7:0] st, vt, mt; logic [31:0] rd;
      drive_req(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (st !== STALL_EXP) begin n_fail++; $display("FAIL sl_store_stall: got %h expected %h", st, STALL_EXP); end
      n_cmp++; if (vt !== 8'h00) begin n_fail++; $display("FAIL sl_store_valid: got %h expected 00", vt); end
      drive_req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (st !== STALL_EXP) begin n_fail++; $display("FAIL sl_load_stall: got %h expected %h", st, STALL_EXP); end
      n_cmp++; if (vt !== RESP_BIT) begin n_fail++; $display("FAIL sl_load_valid: got %h expected %h", vt, RESP_BIT); end
      n_cmp++; if (mt !== 8'h00) begin n_fail++; $display("FAIL sl_load_mis: got %h expected 00", mt); end
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sl_load_data: got %h expected DEADBEEF", rd); end
      @(negedge clk);
      n_cmp++; if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL sl_strobe_one_cycle: got %b expected 0", rdata_valid); end
      n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sl_rdata_hold: got %h expected DEADBEEF", rdata); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_request();
      logic [7:0] st, vt, mt; logic [31:0] rd;
      drive_req(1'b0, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, 1'b0, st, vt, mt, rd);
      drive_req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL rm_pre_load: got %h expected 0BADF00D", rd); end
      mem_write = 1'b1; addr = 32'h10; wdata = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      @(negedge clk);
      n_cmp++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL rm_in_wait: got %b expected 1", mem_stall); end
      rst = 1'b1;
      mem_write = 1'b0;
      #1;
      n_cmp++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall: got %b expected 0", mem_stall); end
      n_cmp++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL rm_rdata: got %h expected 0", rdata); end
      n_cmp++; if (rdata_valid !== 1'b0 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL rm_strobes: got %b%b expected 00", rdata_valid, misalign_err); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (st !== STALL_EXP) begin n_fail++; $display("FAIL rm_post_stall: got %h expected %h", st, STALL_EXP); end
      n_cmp++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL rm_store_aborted: got %h expected 0BADF00D", rd); end
   endtask

   task automatic test_misaligned();
      logic [7:0] st, vt, mt; logic [31:0] rd;
      drive_req(1'b0, 1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 1'b0, st, vt, mt, rd);
      drive_req(1'b1, 1'b0, 32'h22, 32'h0, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (vt !== RESP_BIT) begin n_fail++; $display("FAIL mis_load_valid: got %h expected %h", vt, RESP_BIT); end
      n_cmp++; if (mt !== RESP_BIT) begin n_fail++; $display("FAIL mis_load_err: got %h expected %h", mt, RESP_BIT); end
      n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL mis_load_data: got %h expected 0", rd); end
      drive_req(1'b0, 1'b1, 32'h26, 32'h00000001, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (mt !== RESP_BIT) begin n_fail++; $display("FAIL mis_store_err: got %h expected %h", mt, RESP_BIT); end
      n_cmp++; if (vt !== 8'h00) begin n_fail++; $display("FAIL mis_store_valid: got %h expected 00", vt); end
      drive_req(1'b1, 1'b0, 32'h24, 32'h0, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mis_array_unchanged: got %h expected CAFEF00D", rd); end
      n_cmp++; if (mt !== 8'h00) begin n_fail++; $display("FAIL mis_aligned_no_err: got %h expected 00", mt); end
      drive_req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mis_neighbour: got %h expected DEADBEEF", rd); end
   endtask

   task automatic test_wrap();
      logic [7:0] st, vt, mt; logic [31:0] rd;
      drive_req(1'b0, 1'b1, 32'h400, 32'h12345678, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (mt !== 8'h00) begin n_fail++; $display("FAIL wrap_no_err: got %h expected 00", mt); end
      drive_req(1'b1, 1'b0, 32'h000, 32'h0, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL wrap_load0: got %h expected 12345678", rd); end
      drive_req(1'b1, 1'b0, 32'hFFFF_F420, 32'h0, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wrap_high_alias: got %h expected DEADBEEF", rd); end
   endtask

   task automatic test_read_write();
      logic [7:0] st, vt, mt; logic [31:0] rd;
      drive_req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, st, vt, mt, rd);
      drive_req(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (vt !== 8'h00) begin n_fail++; $display("FAIL rw_no_valid: got %h expected 00", vt); end
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rw_rdata_held: got %h expected DEADBEEF", rd); end
      n_cmp++; if (st !== STALL_EXP) begin n_fail++; $display("FAIL rw_stall: got %h expected %h", st, STALL_EXP); end
      drive_req(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rw_stored: got %h expected A5A5A5A5", rd); end
   endtask

   task automatic test_ignore_wait_inputs();
      logic [7:0] st, vt, mt; logic [31:0] rd;
      drive_req(1'b0, 1'b1, 32'h50, 32'h00000055, 4'hF, 1'b1, st, vt, mt, rd);
      drive_req(1'b1, 1'b0, 32'h50, 32'h0, 4'hF, 1'b1, st, vt, mt, rd);
      n_cmp++; if (rd !== 32'h00000055) begin n_fail++; $display("FAIL ign_data: got %h expected 00000055", rd); end
      n_cmp++; if (vt !== RESP_BIT) begin n_fail++; $display("FAIL ign_valid: got %h expected %h", vt, RESP_BIT); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  st, vt, mt; logic [31:0] rd, ex;
      logic [31:0] vals [4] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
      for (int i = 0; i < 4; i++) begin
         drive_req(1'b0, 1'b1, 32'h60 + 32'(4 * i), vals[i], 4'hF, 1'b0, st, vt, mt, rd);
      end
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(vals[i]);
         drive_req(1'b1, 1'b0, 32'h60 + 32'(4 * i), 32'h0, 4'hF, 1'b0, st, vt, mt, rd);
         ex = exp_q.pop_front();
         n_cmp++; if (st !== STALL_EXP) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %h expected %h", i, st, STALL_EXP); end
         n_cmp++; if (vt !== RESP_BIT) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %h expected %h", i, vt, RESP_BIT); end
         n_cmp++; if (rd !== ex) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rd, ex); end
      end
   endtask

`ifdef DMEM_BYTE_STROBE_EN
   task automatic test_byte_strobe();
      logic [7:0] st, vt, mt; logic [31:0] rd;
      drive_req(1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF, 1'b0, st, vt, mt, rd);
      drive_req(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 1'b0, st, vt, mt, rd);
      drive_req(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL bs_merge: got %h expected 11BB33DD", rd); end
      drive_req(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 1'b0, st, vt, mt, rd);
      n_cmp++; if (st !== STALL_EXP) begin n_fail++; $display("FAIL bs_zero_stall: got %h expected %h", st, STALL_EXP); end
      drive_req(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, st, vt, mt, rd);
      n_cmp++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL bs_zero_strobe: got %h expected 11BB33DD", rd); end
   endtask
`endif

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_store_load();
      test_reset_mid_request();
      test_misaligned();
      test_wrap();
      test_read_write();
      test_ignore_wait_inputs();
      test_back_to_back();
`ifdef DMEM_BYTE_STROBE_EN
      test_byte_strobe();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
